// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the seq_serializer slice: FSM state encoding and
// the parity helper used when SEQ_SER_PARITY_EN is defined.
package seq_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // Even parity over a zero-extended word (extra zero bits do not alter it).
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/seq_ser_bitcnt.sv
// Bit-index counter for seq_serializer: clears, increments and flags the
// terminal count (last data bit, or the parity slot when parity is enabled).
module seq_ser_bitcnt #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TC_VAL = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             tc
);

    // Index register: clear has priority over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + IDX_W'(1);
        end
    end

    assign tc = (idx == IDX_W'(TC_VAL));

endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: loads a WIDTH-bit pattern over valid/ready and shifts it
// out MSB first on ds, one bit per ce strobe, in single-shot or cyclic mode.
// Optional feature macro: SEQ_SER_PARITY_EN (appends an even-parity bit).
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [WIDTH-1:0]             load_data,
    input  logic                         mode,
    input  logic                         stop,
    input  logic                         ce,
    output logic                         ds,
    output logic                         ds_valid,
    output logic [$clog2(WIDTH+1)-1:0]   bit_idx,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             word_cnt
);

    localparam int unsigned IDX_W = $clog2(WIDTH+1);
`ifdef SEQ_SER_PARITY_EN
    localparam int unsigned TC_VAL = WIDTH;
`else
    localparam int unsigned TC_VAL = WIDTH - 1;
`endif

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             tc;
    logic             active;
    logic             word_end;
    logic             cnt_inc;

    assign active   = (state != ST_IDLE);
    // tc is only reachable in the final slot of a word, so ce && tc marks the boundary.
    assign word_end = active && ce && tc;
    assign cnt_inc  = active && ce && !tc;

    seq_ser_bitcnt #(
        .IDX_W  (IDX_W),
        .TC_VAL (TC_VAL)
    ) u_bitcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (word_end),
        .inc   (cnt_inc),
        .idx   (bit_idx),
        .tc    (tc)
    );

    // Control FSM with shift/hold registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            hold_reg   <= '0;
            ds         <= 1'b0;
            ds_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_cnt   <= '0;
            load_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            if (word_end) begin
                // Boundary handling is shared by SHIFT (no parity) and PAR.
                word_cnt <= word_cnt + CNT_W'(1);
                if (mode && !stop) begin
                    shift_reg <= hold_reg;
                    ds        <= hold_reg[WIDTH-1];
                    state     <= ST_SHIFT;
                end else begin
                    state      <= ST_IDLE;
                    ds         <= 1'b0;
                    ds_valid   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    load_ready <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (load_valid && load_ready) begin
                            hold_reg   <= load_data;
                            shift_reg  <= load_data;
                            ds         <= load_data[WIDTH-1];
                            ds_valid   <= 1'b1;
                            busy       <= 1'b1;
                            load_ready <= 1'b0;
                            state      <= ST_SHIFT;
                        end else begin
                            load_ready <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (ce) begin
`ifdef SEQ_SER_PARITY_EN
                            if (bit_idx == IDX_W'(WIDTH-1)) begin
                                ds    <= even_parity(64'(hold_reg));
                                state <= ST_PAR;
                            end else begin
                                shift_reg <= shift_reg << 1;
                                ds        <= shift_reg[WIDTH-2];
                            end
`else
                            shift_reg <= shift_reg << 1;
                            ds        <= shift_reg[WIDTH-2];
`endif
                        end
                    end
`ifdef SEQ_SER_PARITY_EN
                    ST_PAR: begin
                        // PAR only leaves on ce, which is the word_end path above.
                        state <= ST_PAR;
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer (WIDTH=8, CNT_W=8). A position-based
// reference model predicts every output each cycle; directed scenarios are
// followed by randomized traffic. Honours SEQ_SER_PARITY_EN if defined.
module tb_seq_serializer;

    localparam int W  = 8;
    localparam int CW = 8;
    localparam int IW = $clog2(W+1);
`ifdef SEQ_SER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_data;
    logic          mode;
    logic          stop;
    logic          ce;
    logic          ds;
    logic          ds_valid;
    logic [IW-1:0] bit_idx;
    logic          busy;
    logic          done;
    logic [CW-1:0] word_cnt;

    seq_serializer #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .mode       (mode),
        .stop       (stop),
        .ce         (ce),
        .ds         (ds),
        .ds_valid   (ds_valid),
        .bit_idx    (bit_idx),
        .busy       (busy),
        .done       (done),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a word is a sequence of NB slots indexed by position.
    bit           m_busy;
    bit           m_done;
    bit           m_ready;
    int           m_pos;
    logic [W-1:0] m_pat;
    int           m_cnt;

    function automatic logic exp_ds();
        if (!m_busy)     return 1'b0;
        if (m_pos < W)   return m_pat[W-1-m_pos];
        return ($countones(m_pat) % 2) == 1;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_busy = 0; m_done = 0; m_ready = 1; m_pos = 0; m_pat = '0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (m_ready && load_valid) begin
                    m_pat = load_data; m_busy = 1; m_pos = 0; m_ready = 0;
                end else begin
                    m_ready = 1;
                end
            end else if (ce) begin
                if (m_pos < NB - 1) begin
                    m_pos++;
                end else begin
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    m_pos = 0;
                    if (!(mode && !stop)) begin
                        m_busy = 0; m_done = 1; m_ready = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("ds",         32'(ds),         32'(exp_ds()));
        check("ds_valid",   32'(ds_valid),   32'(m_busy));
        check("bit_idx",    32'(bit_idx),    32'(m_pos));
        check("busy",       32'(busy),       32'(m_busy));
        check("done",       32'(done),       32'(m_done));
        check("word_cnt",   32'(word_cnt),   32'(m_cnt));
        check("load_ready", 32'(load_ready), 32'(m_ready));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!load_ready && n < 40) begin step(); n++; end
        if (n >= 40) check("timeout_ready", 32'(load_ready), 32'd1);
    endtask

    // Single-shot word at ce=1; optionally keeps load_valid high with 0xFF mid-word.
    task automatic run_word(input logic [W-1:0] pat, input bit hold_lv,
                            output logic [W-1:0] bits, output logic lastbit);
        wait_ready();
        mode = 0; stop = 0; ce = 1;
        load_valid = 1; load_data = pat;
        step();
        if (hold_lv) load_data = 8'hFF; else load_valid = 0;
        bits = '0;
        for (int i = 0; i < W; i++) begin
            bits = {bits[W-2:0], ds};
            step();
        end
        lastbit = ds;
        for (int i = W; i < NB; i++) step();
        load_valid = 0;
    endtask

    logic [W-1:0] bits;
    logic         lastbit;
    int           j;
    int           n;
    int           start_cnt;

    initial begin
        reset = 1; load_valid = 0; load_data = '0; mode = 0; stop = 0; ce = 0;
        step(); step();
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_busy",  32'(busy),       32'd0);
        reset = 0;
        step();

        // 1: single-shot 0xB4 at full rate
        run_word(8'hB4, 0, bits, lastbit);
        check("t1_bits",  32'(bits),     32'hB4);
        check("t1_done",  32'(done),     32'd1);
        check("t1_cnt",   32'(word_cnt), 32'd1);
        step();
        check("t1_ready", 32'(load_ready), 32'd1);

        // 2: 0x81 with ce every third cycle, measure busy span
        wait_ready();
        mode = 0; ce = 0; load_valid = 1; load_data = 8'h81;
        step();
        load_valid = 0;
        j = 1;
        while (busy && j < 200) begin
            ce = (j % 3 == 0);
            step();
            if (busy) j++;
        end
        ce = 0;
        check("t2_busy_clks", 32'(j), 32'(3 * NB));

        // 3: cyclic 0x0F, stop raised during word 3
        wait_ready();
        start_cnt = int'(word_cnt);
        mode = 1; stop = 0; ce = 1; load_valid = 1; load_data = 8'h0F;
        step();
        load_valid = 0;
        n = 0;
        while (int'(word_cnt) != start_cnt + 2 && n < 100) begin step(); n++; end
        repeat (3) step();
        stop = 1;
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        check("t3_words", 32'(int'(word_cnt) - start_cnt), 32'd3);
        check("t3_idle",  32'(busy), 32'd0);
        mode = 0; stop = 0;

        // 4: load_valid held with 0xFF during shifting is ignored
        run_word(8'h5A, 1, bits, lastbit);
        check("t4_bits", 32'(bits), 32'h5A);

        // 5: reset at bit_idx 4 aborts the word
        wait_ready();
        ce = 1; load_valid = 1; load_data = 8'hA5;
        step();
        load_valid = 0;
        n = 0;
        while (bit_idx != IW'(4) && n < 20) begin step(); n++; end
        reset = 1;
        step();
        reset = 0;
        check("t5_busy", 32'(busy),     32'd0);
        check("t5_cnt",  32'(word_cnt), 32'd0);
        check("t5_done", 32'(done),     32'd0);

`ifdef SEQ_SER_PARITY_EN
        // 6: parity slot
        run_word(8'h07, 0, bits, lastbit);
        check("t6_par07", 32'(lastbit), 32'd1);
        run_word(8'h03, 0, bits, lastbit);
        check("t6_par03", 32'(lastbit), 32'd0);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 199) == 0);
            load_valid = $urandom_range(0, 1);
            load_data  = W'($urandom);
            mode       = ($urandom_range(0, 3) != 0);
            stop       = ($urandom_range(0, 3) == 0);
            ce         = ($urandom_range(0, 9) < 6);
            step();
        end
        reset = 0; load_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
